// File: rtl/add_np_pkg.sv
// Shared constants and segment-geometry helpers for the add_np pipelined adder.
// Saturation is an optional feature of add_np, enabled by defining ADD_NP_SAT_EN.
package add_np_pkg;

  localparam int MAX_NSEG = 8;

  // Mode encoding of the sub input.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int seg_width(input int width, input int nseg);
    return (width + nseg - 1) / nseg;
  endfunction

  function automatic int top_width(input int width, input int nseg);
    return width - (nseg - 1) * seg_width(width, nseg);
  endfunction

endpackage

// File: rtl/add_np_seg.sv
// One segment register of the carry pipeline: a W-bit carry-absorb adder whose result
// is exposed combinationally, then registered from a separately supplied load value.
module add_np_seg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  input  logic         cin_i,
  output logic [W-1:0] s_d_o,
  output logic         c_d_o,
  input  logic [W-1:0] s_load_i,
  input  logic         c_load_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  logic [W:0]   sum_w;
  logic [W-1:0] s_q;
  logic         c_q;

  assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign s_d_o = sum_w[W-1:0];
  // A segment that already carried cannot carry again when absorbing a single bit.
  assign c_d_o = c_i | sum_w[W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else if (en_i) begin
      s_q <= s_load_i;
      c_q <= c_load_i;
    end
  end

  assign s_o = s_q;
  assign c_o = c_q;

endmodule

// File: rtl/add_np.sv
// Pipelined segmented adder/subtractor: capture stage plus one carry-resolve stage per segment.
// Defining ADD_NP_SAT_EN saturates the result on signed overflow.
module add_np
  import add_np_pkg::*;
#(
  parameter int WIDTH = 29,
  parameter int NSEG  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEGW = seg_width(WIDTH, NSEG);
  localparam int TOPW = top_width(WIDTH, NSEG);

  if (NSEG < 1 || NSEG > MAX_NSEG || TOPW < 1) begin : g_bad_cfg
    $error("add_np: unsupported WIDTH/NSEG combination");
  end

  // Valid/ready: a transfer occurs on a rising edge with valid && ready on the same side.
  // The whole pipeline moves in lockstep whenever the output slot is empty or draining,
  // so in_ready is exactly that enable; bubbles are carried, never squeezed out.
  logic en;

  logic [WIDTH-1:0] a_q, b_q, b_d;
  logic             cin_q;
  logic [NSEG:0]    v_q;
  logic [NSEG-1:0]  am_q, bm_q;
  logic             ovf_q, ovf_d;
  wire              raw_msb;

  wire [NSEG:1][WIDTH-1:0] pipe_s;
  wire [NSEG:1][NSEG-1:0]  pipe_c;

  assign out_valid = v_q[NSEG];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign b_d       = (sub == ADD) ? y : ~y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      v_q   <= '0;
      am_q  <= '0;
      bm_q  <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      a_q     <= x;
      b_q     <= b_d;
      cin_q   <= (sub == SUB);
      v_q[0]  <= in_valid && in_ready;
      am_q[0] <= x[WIDTH-1];
      bm_q[0] <= b_d[WIDTH-1];
      for (int i = 1; i <= NSEG; i++) v_q[i] <= v_q[i-1];
      for (int i = 1; i < NSEG; i++) begin
        am_q[i] <= am_q[i-1];
        bm_q[i] <= bm_q[i-1];
      end
      ovf_q <= ovf_d;
    end
  end

  // Overflow is judged on the fully resolved top segment entering the last register.
  assign ovf_d = (am_q[NSEG-1] == bm_q[NSEG-1]) && (raw_msb != am_q[NSEG-1]);

`ifdef ADD_NP_SAT_EN
  logic [WIDTH-1:0] sat_word;
  assign sat_word = {am_q[NSEG-1], {(WIDTH-1){~am_q[NSEG-1]}}};
`endif

  for (genvar j = 1; j <= NSEG; j++) begin : g_stage
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
      localparam int LO = k * SEGW;
      localparam int WK = (k == NSEG - 1) ? TOPW : SEGW;

      logic [WK-1:0] a_w, b_w, sd_w, sl_w;
      logic          c_w, cin_w, cd_w;

      if (j == 1) begin : g_first
        assign a_w   = a_q[LO +: WK];
        assign b_w   = b_q[LO +: WK];
        assign c_w   = 1'b0;
        assign cin_w = (k == 0) ? cin_q : 1'b0;
      end else begin : g_absorb
        // Only segment j-1 takes a carry here, so each stage ripples one segment at most.
        assign a_w   = pipe_s[j-1][LO +: WK];
        assign b_w   = '0;
        assign c_w   = pipe_c[j-1][k];
        assign cin_w = (k == j - 1) ? pipe_c[j-1][j-2] : 1'b0;
      end

      if (j == NSEG) begin : g_load_last
`ifdef ADD_NP_SAT_EN
        assign sl_w = ovf_d ? sat_word[LO +: WK] : sd_w;
`else
        assign sl_w = sd_w;
`endif
      end else begin : g_load
        assign sl_w = sd_w;
      end

      if (j == NSEG && k == NSEG - 1) begin : g_msb
        assign raw_msb = sd_w[WK-1];
      end

      add_np_seg #(.W(WK)) u_seg (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (en),
        .a_i      (a_w),
        .b_i      (b_w),
        .c_i      (c_w),
        .cin_i    (cin_w),
        .s_d_o    (sd_w),
        .c_d_o    (cd_w),
        .s_load_i (sl_w),
        .c_load_i (cd_w),
        .s_o      (pipe_s[j][LO +: WK]),
        .c_o      (pipe_c[j][k])
      );
    end
  end

  assign sum  = pipe_s[NSEG];
  assign cout = pipe_c[NSEG][NSEG-1];
  assign ovf  = ovf_q;

  // Lower-segment carries of the last stage have already been absorbed upstream.
  logic unused_ok;
  assign unused_ok = &{1'b0, pipe_c[NSEG]};

endmodule

// File: tb/tb_add_np.sv
// Directed self-checking bench for add_np at default parameters (WIDTH=29, NSEG=4).
// Expectations follow ADD_NP_SAT_EN when the bench is built with it defined.
module tb_add_np;

  localparam int W = 29;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  add_np #(.WIDTH(W), .NSEG(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; sends one operand pair and follows it to the output.
  task automatic run_one(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic sv, input logic [W-1:0] es, input logic ec,
                         input logic eo);
    int lat;
    in_valid = 1'b1;
    x = xv;
    y = yv;
    sub = sv;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    sub = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk);
    #1;
    chk({tag, "_single"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    int got;
    int stale;
    logic stall;

    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sub = 1'b0;
    x = '0;
    y = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors
    run_one("ripple", 29'h000007F, 29'h0000001, 1'b0, 29'h0000080, 1'b0, 1'b0);
    run_one("fullcarry", 29'h1FFFFFFF, 29'h0000001, 1'b0, 29'h0000000, 1'b1, 1'b0);
    run_one("sub_borrow", 29'd5, 29'd7, 1'b1, 29'h1FFFFFFE, 1'b0, 1'b0);
    run_one("sub_noborrow", 29'd7, 29'd5, 1'b1, 29'd2, 1'b1, 1'b0);
    run_one("midcarry", 29'h00FF00FF, 29'h00010001, 1'b0, 29'h01000100, 1'b0, 1'b0);
`ifdef ADD_NP_SAT_EN
    run_one("pos_ovf", 29'h0FFFFFFF, 29'd1, 1'b0, 29'h0FFFFFFF, 1'b0, 1'b1);
    run_one("neg_ovf", 29'h10000000, 29'h10000000, 1'b0, 29'h10000000, 1'b1, 1'b1);
    run_one("sub_ovf", 29'h10000000, 29'd1, 1'b1, 29'h10000000, 1'b1, 1'b1);
`else
    run_one("pos_ovf", 29'h0FFFFFFF, 29'd1, 1'b0, 29'h10000000, 1'b0, 1'b1);
    run_one("neg_ovf", 29'h10000000, 29'h10000000, 1'b0, 29'h00000000, 1'b1, 1'b1);
    run_one("sub_ovf", 29'h10000000, 29'd1, 1'b1, 29'h0FFFFFFF, 1'b1, 1'b1);
`endif

    // Backpressure: 10 back-to-back operands, out_ready low on cycles 8..10
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      stall = (cyc >= 8 && cyc <= 10);
      in_valid = (sent < 10);
      x = W'(sent);
      y = W'(100 * sent);
      sub = 1'b0;
      out_ready = !stall;
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(!stall));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_result", 32'(sum), 32'hFFFFFFFF);
        end else begin
          chk("bp_sum", 32'(sum), 32'(exp_q.pop_front()));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(W'(101 * sent));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    x = '0;
    y = '0;
    out_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd10);
    chk("bp_sent", 32'(sent), 32'd10);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_no_extra", 32'(out_valid), 32'd0);

    // Reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x = W'(1000 + i);
      y = W'(7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_first_valid", 32'(out_valid), 32'd1);
    chk("mid_first_sum", 32'(sum), 32'd1007);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);
    run_one("after_rst", 29'd300, 29'd45, 1'b0, 29'd345, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
